// File: rtl/dac_command_decoder.sv
// rtl/dac_command_decoder.sv - RTO command word decoder with staged DDS parameters and amplitude ramp
module dac_command_decoder #(
    parameter int FREQ_WIDTH  = 48,
    parameter int PHASE_WIDTH = 16,
    parameter int AMP_WIDTH   = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   counter_matched,
    input  logic [127:0]           rto_out,
    output logic [FREQ_WIDTH-1:0]  freq_out,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic [AMP_WIDTH-1:0]   amp_out,
    output logic                   param_update,
    output logic                   ramp_busy,
    output logic                   illegal_cmd,
    output logic [127:0]           illegal_cmd_data,
    output logic [31:0]            cmd_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_SET_FREQ  = 4'h1;
    localparam logic [3:0] OP_SET_PHASE = 4'h2;
    localparam logic [3:0] OP_SET_AMP   = 4'h3;
    localparam logic [3:0] OP_APPLY     = 4'h4;
    localparam logic [3:0] OP_RAMP_AMP  = 4'h5;

    state_t                 state_q, state_d;
    logic [FREQ_WIDTH-1:0]  freq_shadow_q, freq_shadow_d;
    logic [PHASE_WIDTH-1:0] phase_shadow_q, phase_shadow_d;
    logic [AMP_WIDTH-1:0]   amp_shadow_q, amp_shadow_d;
    logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [AMP_WIDTH-1:0]   amp_q, amp_d;
    logic [AMP_WIDTH-1:0]   target_q, target_d;
    logic [AMP_WIDTH-1:0]   step_q, step_d;
    logic                   param_update_q, param_update_d;
    logic                   illegal_q, illegal_d;
    logic [127:0]           illegal_data_q, illegal_data_d;
    logic [31:0]            cmd_count_q, cmd_count_d;

    logic [3:0]             opcode;
    logic                   ramp_up;
    logic [AMP_WIDTH:0]     diff;

    // Timestamp and the gap above the frequency field carry nothing for this block.
    logic unused_rto_bits;
    assign unused_rto_bits = ^{rto_out[127:64], rto_out[59:48]};

    assign opcode = rto_out[63:60];
    assign ramp_up = (amp_q < target_q);
    assign diff = ramp_up ? ({1'b0, target_q} - {1'b0, amp_q})
                          : ({1'b0, amp_q} - {1'b0, target_q});

    always_comb begin
        state_d        = state_q;
        freq_shadow_d  = freq_shadow_q;
        phase_shadow_d = phase_shadow_q;
        amp_shadow_d   = amp_shadow_q;
        freq_d         = freq_q;
        phase_d        = phase_q;
        amp_d          = amp_q;
        target_d       = target_q;
        step_d         = step_q;
        param_update_d = 1'b0;
        illegal_d      = illegal_q;
        illegal_data_d = illegal_data_q;
        cmd_count_d    = cmd_count_q;

        if (state_q == RAMP) begin
            param_update_d = 1'b1;
            if ((step_q == '0) || (diff <= {1'b0, step_q})) begin
                amp_d   = target_q;
                state_d = IDLE;
            end else if (ramp_up) begin
                amp_d = amp_q + step_q;
            end else begin
                amp_d = amp_q - step_q;
            end
        end

        // A command on the same edge as a ramp step overrides the step where they collide.
        if (counter_matched) begin
            case (opcode)
                OP_NOP: begin
                    cmd_count_d = cmd_count_q + 32'd1;
                end
                OP_SET_FREQ: begin
                    freq_shadow_d = rto_out[FREQ_WIDTH-1:0];
                    cmd_count_d   = cmd_count_q + 32'd1;
                end
                OP_SET_PHASE: begin
                    phase_shadow_d = rto_out[PHASE_WIDTH-1:0];
                    cmd_count_d    = cmd_count_q + 32'd1;
                end
                OP_SET_AMP: begin
                    amp_shadow_d = rto_out[AMP_WIDTH-1:0];
                    cmd_count_d  = cmd_count_q + 32'd1;
                end
                OP_APPLY: begin
                    freq_d         = freq_shadow_q;
                    phase_d        = phase_shadow_q;
                    amp_d          = amp_shadow_q;
                    state_d        = IDLE;
                    param_update_d = 1'b1;
                    cmd_count_d    = cmd_count_q + 32'd1;
                end
                OP_RAMP_AMP: begin
                    target_d       = rto_out[AMP_WIDTH-1:0];
                    step_d         = rto_out[16 +: AMP_WIDTH];
                    amp_d          = amp_q;
                    state_d        = RAMP;
                    param_update_d = 1'b0;
                    cmd_count_d    = cmd_count_q + 32'd1;
                end
                default: begin
                    illegal_d      = 1'b1;
                    illegal_data_d = rto_out;
                end
            endcase
        end

        if (flush) begin
            illegal_d      = 1'b0;
            illegal_data_d = '0;
            cmd_count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            freq_shadow_q  <= '0;
            phase_shadow_q <= '0;
            amp_shadow_q   <= '0;
            freq_q         <= '0;
            phase_q        <= '0;
            amp_q          <= '0;
            target_q       <= '0;
            step_q         <= '0;
            param_update_q <= 1'b0;
            illegal_q      <= 1'b0;
            illegal_data_q <= '0;
            cmd_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            freq_shadow_q  <= freq_shadow_d;
            phase_shadow_q <= phase_shadow_d;
            amp_shadow_q   <= amp_shadow_d;
            freq_q         <= freq_d;
            phase_q        <= phase_d;
            amp_q          <= amp_d;
            target_q       <= target_d;
            step_q         <= step_d;
            param_update_q <= param_update_d;
            illegal_q      <= illegal_d;
            illegal_data_q <= illegal_data_d;
            cmd_count_q    <= cmd_count_d;
        end
    end

    assign freq_out         = freq_q;
    assign phase_out        = phase_q;
    assign amp_out          = amp_q;
    assign param_update     = param_update_q;
    assign ramp_busy        = (state_q == RAMP);
    assign illegal_cmd      = illegal_q;
    assign illegal_cmd_data = illegal_data_q;
    assign cmd_count        = cmd_count_q;

endmodule

// File: tb/tb_dac_command_decoder.sv
// tb/tb_dac_command_decoder.sv - directed self-checking bench for dac_command_decoder
module tb_dac_command_decoder;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         counter_matched;
    logic [127:0] rto_out;
    logic [47:0]  freq_out;
    logic [15:0]  phase_out;
    logic [13:0]  amp_out;
    logic         param_update;
    logic         ramp_busy;
    logic         illegal_cmd;
    logic [127:0] illegal_cmd_data;
    logic [31:0]  cmd_count;

    int n_checks = 0;
    int n_fail   = 0;

    dac_command_decoder dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .counter_matched  (counter_matched),
        .rto_out          (rto_out),
        .freq_out         (freq_out),
        .phase_out        (phase_out),
        .amp_out          (amp_out),
        .param_update     (param_update),
        .ramp_busy        (ramp_busy),
        .illegal_cmd      (illegal_cmd),
        .illegal_cmd_data (illegal_cmd_data),
        .cmd_count        (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one command for a single cycle; returns at N+1 sampling point.
    task automatic send(input logic [63:0] payload);
        counter_matched = 1'b1;
        rto_out = {64'hCAFE_0000_0000_1111, payload};
        tick(1);
        counter_matched = 1'b0;
        rto_out = '0;
    endtask

    int exp_amp[4]  = '{30, 60, 90, 100};
    int exp_busy[4] = '{1, 1, 1, 0};

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        counter_matched = 1'b0;
        rto_out = '0;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst_freq", freq_out, 0);
        chk("rst_phase", phase_out, 0);
        chk("rst_amp", amp_out, 0);
        chk("rst_pu", param_update, 0);
        chk("rst_busy", ramp_busy, 0);
        chk("rst_ill", illegal_cmd, 0);
        chk("rst_ill_data", illegal_cmd_data, 0);
        chk("rst_count", cmd_count, 0);

        // Staged writes stay hidden until APPLY
        send(64'h1000_1234_5678_9ABC);
        chk("stage_freq_hidden", freq_out, 0);
        send(64'h2000_0000_0000_4000);
        send(64'h3000_0000_0000_1FFF);
        chk("stage_amp_hidden", amp_out, 0);
        chk("stage_pu", param_update, 0);
        send(64'h4000_0000_0000_0000);
        chk("apply_freq", freq_out, 48'h1234_5678_9ABC);
        chk("apply_phase", phase_out, 16'h4000);
        chk("apply_amp", amp_out, 14'h1FFF);
        chk("apply_pu", param_update, 1);
        chk("apply_count", cmd_count, 4);
        tick(1);
        chk("apply_pu_single", param_update, 0);

        // Upward ramp 0 -> 100 step 30
        send(64'h3000_0000_0000_0000);
        send(64'h4000_0000_0000_0000);
        chk("ramp1_start_amp", amp_out, 0);
        send(64'h5000_0000_001E_0064);
        chk("ramp1_n1_amp", amp_out, 0);
        chk("ramp1_n1_busy", ramp_busy, 1);
        chk("ramp1_n1_pu", param_update, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk($sformatf("ramp1_amp%0d", i), amp_out, exp_amp[i]);
            chk($sformatf("ramp1_busy%0d", i), ramp_busy, exp_busy[i]);
            chk($sformatf("ramp1_pu%0d", i), param_update, 1);
        end
        tick(1);
        chk("ramp1_done_amp", amp_out, 100);
        chk("ramp1_done_pu", param_update, 0);

        // Step 0 jumps straight to target (downward)
        send(64'h5000_0000_0000_000A);
        chk("jump_n1_amp", amp_out, 100);
        chk("jump_n1_busy", ramp_busy, 1);
        tick(1);
        chk("jump_n2_amp", amp_out, 10);
        chk("jump_n2_busy", ramp_busy, 0);
        chk("jump_n2_pu", param_update, 1);

        // APPLY aborts a running ramp
        send(64'h3000_0000_0000_0000);
        send(64'h4000_0000_0000_0000);
        send(64'h3000_0000_0000_01F4);
        send(64'h5000_0000_000A_03E8);
        chk("abort_n1_amp", amp_out, 0);
        tick(3);
        chk("abort_n4_amp", amp_out, 30);
        chk("abort_n4_busy", ramp_busy, 1);
        send(64'h4000_0000_0000_0000);
        chk("abort_amp", amp_out, 500);
        chk("abort_busy", ramp_busy, 0);
        chk("abort_pu", param_update, 1);
        tick(2);
        chk("abort_hold_amp", amp_out, 500);
        chk("abort_hold_pu", param_update, 0);
        chk("count_13", cmd_count, 13);

        // Illegal opcode, flush, and flush racing an illegal command
        counter_matched = 1'b1;
        rto_out = 128'hDEAD_BEEF_0000_0000_9000_0000_0000_0001;
        tick(1);
        counter_matched = 1'b0;
        rto_out = '0;
        chk("ill_flag", illegal_cmd, 1);
        chk("ill_data", illegal_cmd_data, 128'hDEAD_BEEF_0000_0000_9000_0000_0000_0001);
        chk("ill_count", cmd_count, 13);
        chk("ill_amp", amp_out, 500);
        chk("ill_pu", param_update, 0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_flag", illegal_cmd, 0);
        chk("flush_data", illegal_cmd_data, 0);
        chk("flush_count", cmd_count, 0);
        chk("flush_amp", amp_out, 500);
        flush = 1'b1;
        send(64'hF000_0000_0000_0002);
        flush = 1'b0;
        chk("flush_race_flag", illegal_cmd, 0);
        chk("flush_race_data", illegal_cmd_data, 0);

        // Counter wrap from all-ones
        force dut.cmd_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.cmd_count_q;
        chk("wrap_preload", cmd_count, 32'hFFFF_FFFF);
        send(64'h0000_0000_0000_0000);
        chk("wrap_zero", cmd_count, 0);

        // Reset mid-ramp beats a simultaneous command
        send(64'h5000_0000_000A_03E8);
        tick(1);
        chk("rst_ramp_amp", amp_out, 510);
        reset = 1'b1;
        send(64'h4000_0000_0000_0000);
        reset = 1'b0;
        chk("rst_mid_amp", amp_out, 0);
        chk("rst_mid_busy", ramp_busy, 0);
        chk("rst_mid_freq", freq_out, 0);
        chk("rst_mid_pu", param_update, 0);
        chk("rst_mid_count", cmd_count, 0);
        send(64'h4000_0000_0000_0000);
        chk("rst_shadow_amp", amp_out, 0);
        chk("rst_shadow_freq", freq_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
